// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;
  localparam int LINE_BYTES = 64;
  localparam int LINE_BITS  = LINE_BYTES * 8;
  localparam int OFFSET_WID = 6;
  localparam int WSEL_WID   = OFFSET_WID - 2;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  // Little-endian word pick: word w is bytes 4w..4w+3.
  function automatic logic [31:0] line_word(input logic [LINE_BITS-1:0] line,
                                            input logic [WSEL_WID-1:0] sel);
    return line[32*sel +: 32];
  endfunction
endpackage

// File: rtl/icache_line_ram.sv
// Line storage: valid/tag/data per line, async read, sync write.
module icache_line_ram
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int IDX_WID   = 4,
  parameter int TAG_WID   = 22
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [IDX_WID-1:0]   wr_idx,
  input  logic [TAG_WID-1:0]   wr_tag,
  input  logic [LINE_BITS-1:0] wr_data,
  input  logic [IDX_WID-1:0]   rd_idx,
  output logic                 rd_vld,
  output logic [TAG_WID-1:0]   rd_tag,
  output logic [LINE_BITS-1:0] rd_data
);
  logic [NUM_LINES-1:0] vld_q;
  logic [TAG_WID-1:0]   tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0] data_q [NUM_LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  vld_q <= '0;
    else if (we) vld_q[wr_idx] <= 1'b1;
  end

  // Tag/data need no reset: they are only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_vld  = vld_q[rd_idx];
  assign rd_tag  = tag_q[rd_idx];
  assign rd_data = data_q[rd_idx];
endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache; fills whole lines from the
// memory controller IF port and squashes replies across a rollback.
module icache
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int ADDR_WID  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 fetch_en,
  input  logic [ADDR_WID-1:0]  fetch_pc,
  output logic                 fetch_done,
  output logic [31:0]          fetch_inst,
  output logic                 mem_if_en,
  output logic [ADDR_WID-1:0]  mem_if_pc,
  input  logic                 mem_if_done,
  input  logic [LINE_BITS-1:0] mem_if_data
);
  localparam int IDX_WID = $clog2(NUM_LINES);
  localparam int TAG_WID = ADDR_WID - OFFSET_WID - IDX_WID;

  state_e              state_q, state_d;
  logic                fetch_done_q, fetch_done_d;
  logic [31:0]         fetch_inst_q, fetch_inst_d;
  logic                mem_if_en_q, mem_if_en_d;
  logic [ADDR_WID-1:0] mem_if_pc_q, mem_if_pc_d;
  logic [ADDR_WID-1:2] pc_q, pc_d;
  logic                squash_q, squash_d;

  logic                 we;
  logic                 rd_vld;
  logic [TAG_WID-1:0]   rd_tag;
  logic [LINE_BITS-1:0] rd_data;
  logic                 hit;
  logic                 unused_pc_lsb;

  assign unused_pc_lsb = ^fetch_pc[1:0];

  icache_line_ram #(
    .NUM_LINES (NUM_LINES),
    .IDX_WID   (IDX_WID),
    .TAG_WID   (TAG_WID)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .wr_idx  (pc_q[OFFSET_WID +: IDX_WID]),
    .wr_tag  (pc_q[ADDR_WID-1 -: TAG_WID]),
    .wr_data (mem_if_data),
    .rd_idx  (fetch_pc[OFFSET_WID +: IDX_WID]),
    .rd_vld  (rd_vld),
    .rd_tag  (rd_tag),
    .rd_data (rd_data)
  );

  assign hit = rd_vld && (rd_tag == fetch_pc[ADDR_WID-1 -: TAG_WID]);

  always_comb begin
    state_d      = state_q;
    fetch_done_d = fetch_done_q;
    fetch_inst_d = fetch_inst_q;
    mem_if_en_d  = mem_if_en_q;
    mem_if_pc_d  = mem_if_pc_q;
    pc_d         = pc_q;
    squash_d     = squash_q;
    we           = 1'b0;
    if (rdy) begin
      unique case (state_q)
        IDLE: begin
          // A pending done pulse costs one bubble before the next accept.
          if (fetch_done_q) begin
            fetch_done_d = 1'b0;
          end else if (fetch_en && !rollback) begin
            if (hit) begin
              fetch_done_d = 1'b1;
              fetch_inst_d = line_word(rd_data, fetch_pc[OFFSET_WID-1:2]);
            end else begin
              mem_if_en_d = 1'b1;
              mem_if_pc_d = {fetch_pc[ADDR_WID-1:OFFSET_WID], {OFFSET_WID{1'b0}}};
              pc_d        = fetch_pc[ADDR_WID-1:2];
              squash_d    = 1'b0;
              state_d     = FILL;
            end
          end
        end
        FILL: begin
          // The burst always completes; rollback only suppresses the reply.
          squash_d = squash_q || rollback;
          if (mem_if_done) begin
            we          = 1'b1;
            mem_if_en_d = 1'b0;
            state_d     = IDLE;
            if (!(squash_q || rollback)) begin
              fetch_done_d = 1'b1;
              fetch_inst_d = line_word(mem_if_data, pc_q[OFFSET_WID-1:2]);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fetch_done_q <= 1'b0;
      fetch_inst_q <= '0;
      mem_if_en_q  <= 1'b0;
      mem_if_pc_q  <= '0;
      pc_q         <= '0;
      squash_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_done_q <= fetch_done_d;
      fetch_inst_q <= fetch_inst_d;
      mem_if_en_q  <= mem_if_en_d;
      mem_if_pc_q  <= mem_if_pc_d;
      pc_q         <= pc_d;
      squash_q     <= squash_d;
    end
  end

  assign fetch_done = fetch_done_q;
  assign fetch_inst = fetch_inst_q;
  assign mem_if_en  = mem_if_en_q;
  assign mem_if_pc  = mem_if_pc_q;
endmodule

// File: tb/tb_icache.sv
// Randomized bench for icache against a lookup-table model of cache contents
// and a memory whose byte values are a fixed function of the address.
module tb_icache;
  import icache_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n, rdy, rollback, fetch_en;
  logic [31:0]          fetch_pc;
  logic                 fetch_done;
  logic [31:0]          fetch_inst;
  logic                 mem_if_en;
  logic [31:0]          mem_if_pc;
  logic                 mem_if_done;
  logic [LINE_BITS-1:0] mem_if_data;

  always #5 clk = ~clk;

  icache #(.NUM_LINES(16), .ADDR_WID(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rdy         (rdy),
    .rollback    (rollback),
    .fetch_en    (fetch_en),
    .fetch_pc    (fetch_pc),
    .fetch_done  (fetch_done),
    .fetch_inst  (fetch_inst),
    .mem_if_en   (mem_if_en),
    .mem_if_pc   (mem_if_pc),
    .mem_if_done (mem_if_done),
    .mem_if_data (mem_if_data)
  );

  int checks = 0;
  int failures = 0;

  bit          ref_vld [16];
  logic [21:0] ref_tag [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line at 0x100 holds bytes 0x00..0x3F; other tags perturb the pattern.
  function automatic logic [7:0] mb(input logic [31:0] a);
    return a[7:0] ^ a[17:10];
  endfunction

  function automatic logic [LINE_BITS-1:0] line_data(input logic [31:0] base);
    logic [LINE_BITS-1:0] d;
    for (int k = 0; k < LINE_BYTES; k++) d[8*k +: 8] = mb(base + k);
    return d;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    logic [31:0] a;
    a = pc & 32'hFFFF_FFFC;
    return {mb(a + 3), mb(a + 2), mb(a + 1), mb(a)};
  endfunction

  // mode: 0 plain, 1 rollback mid-fill, 2 rollback on done cycle,
  //       3 rdy stall mid-fill and on the done cycle, 4 rollback with request
  task automatic fetch(input logic [31:0] pc, input int mode);
    logic [3:0]  idx;
    logic [21:0] tg;
    logic [31:0] line;
    bit          hit, squashed;
    int          dly;
    idx  = pc[9:6];
    tg   = pc[31:10];
    line = pc & 32'hFFFF_FFC0;
    hit  = ref_vld[idx] && (ref_tag[idx] == tg);
    dly  = $urandom_range(0, 3);
    if (mode == 1 && dly == 0) dly = 1;

    fetch_en = 1'b1;
    fetch_pc = pc;
    rollback = (mode == 4);
    tick();
    if (mode == 4) begin
      rollback = 1'b0;
      fetch_en = 1'b0;
      check("rb_idle_done", {31'b0, fetch_done}, 32'd0);
      check("rb_idle_req", {31'b0, mem_if_en}, 32'd0);
      tick();
      check("rb_idle_quiet", {31'b0, fetch_done | mem_if_en}, 32'd0);
      return;
    end

    if (hit) begin
      check("hit_done", {31'b0, fetch_done}, 32'd1);
      check("hit_inst", fetch_inst, exp_word(pc));
      check("hit_noreq", {31'b0, mem_if_en}, 32'd0);
      fetch_en = 1'b0;
      tick();
      check("hit_pulse", {31'b0, fetch_done}, 32'd0);
      return;
    end

    check("miss_req", {31'b0, mem_if_en}, 32'd1);
    check("miss_pc", mem_if_pc, line);
    check("miss_nodone", {31'b0, fetch_done}, 32'd0);
    for (int i = 0; i < dly; i++) begin
      if (mode == 1 && i == 0) begin
        rollback = 1'b1;
        fetch_en = 1'b0;
      end
      tick();
      rollback = 1'b0;
      check("fill_hold", {31'b0, mem_if_en}, 32'd1);
      check("fill_pc", mem_if_pc, line);
      check("fill_nodone", {31'b0, fetch_done}, 32'd0);
    end
    if (mode == 3) begin
      rdy = 1'b0;
      repeat (5) begin
        tick();
        check("stall_fill_en", {31'b0, mem_if_en}, 32'd1);
        check("stall_fill_pc", mem_if_pc, line);
        check("stall_fill_done", {31'b0, fetch_done}, 32'd0);
      end
      rdy = 1'b1;
    end

    mem_if_done = 1'b1;
    mem_if_data = line_data(line);
    if (mode == 2) begin
      rollback = 1'b1;
      fetch_en = 1'b0;
    end
    tick();
    mem_if_done = 1'b0;
    mem_if_data = '0;
    rollback    = 1'b0;
    ref_vld[idx] = 1'b1;
    ref_tag[idx] = tg;
    squashed = (mode == 1 || mode == 2);
    check("fill_drop", {31'b0, mem_if_en}, 32'd0);
    check("fill_done", {31'b0, fetch_done}, squashed ? 32'd0 : 32'd1);
    if (!squashed) check("fill_inst", fetch_inst, exp_word(pc));
    fetch_en = 1'b0;
    if (mode == 3) begin
      rdy = 1'b0;
      repeat (5) begin
        tick();
        check("stall_done", {31'b0, fetch_done}, 32'd1);
        check("stall_inst", fetch_inst, exp_word(pc));
      end
      rdy = 1'b1;
    end
    tick();
    check("fill_pulse", {31'b0, fetch_done}, 32'd0);
    check("fill_noreq", {31'b0, mem_if_en}, 32'd0);
  endtask

  initial begin
    int r;
    rst_n = 1'b0; rdy = 1'b1; rollback = 1'b0; fetch_en = 1'b0;
    fetch_pc = '0; mem_if_done = 1'b0; mem_if_data = '0;
    for (int i = 0; i < 16; i++) begin ref_vld[i] = 1'b0; ref_tag[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", {31'b0, fetch_done}, 32'd0);
    check("rst_inst", fetch_inst, 32'd0);
    check("rst_en", {31'b0, mem_if_en}, 32'd0);
    check("rst_pc", mem_if_pc, 32'd0);
    rst_n = 1'b1;
    tick();

    fetch(32'h0000_0104, 0);
    check("tp_cold_word", fetch_inst, 32'h0706_0504);
    fetch(32'h0000_013C, 0);
    check("tp_hit_word", fetch_inst, 32'h3F3E_3D3C);
    fetch(32'h0000_0500, 0);
    fetch(32'h0000_0104, 0);
    fetch(32'h0000_0208, 1);
    fetch(32'h0000_0208, 0);
    fetch(32'h0000_030C, 2);
    fetch(32'h0000_030C, 0);
    fetch(32'h0000_0104, 4);
    fetch(32'h0000_0704, 4);
    fetch(32'h0000_0440, 3);

    // Reset in the middle of a fill.
    fetch_en = 1'b1;
    fetch_pc = 32'h0000_0880;
    tick();
    check("rstfill_req", {31'b0, mem_if_en}, 32'd1);
    fetch_en = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("rstfill_en", {31'b0, mem_if_en}, 32'd0);
    check("rstfill_pc", mem_if_pc, 32'd0);
    check("rstfill_inst", fetch_inst, 32'd0);
    check("rstfill_done", {31'b0, fetch_done}, 32'd0);
    for (int i = 0; i < 16; i++) ref_vld[i] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    fetch(32'h0000_0104, 0);
    fetch(32'h0000_0880, 0);

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      fetch($urandom & 32'h0000_0FFF, (r <= 5) ? 0 : r - 5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
